// File: rtl/control_sequence_packer_if.sv
// Output handshake of the control-sequence packer: the head word pair of
// the FIFO and its valid/ready pair.
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head pair this cycle
//   out_rs1    head pair, rs1 word (older vectors)
//   out_rs2    head pair, rs2 word (newer vectors)
// master: the packer (drives valid/data). slave: the consumer (drives ready).
interface control_sequence_packer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;

  modport master (output out_valid, output out_rs1, output out_rs2, input out_ready);
  modport slave  (input out_valid, input out_rs1, input out_rs2, output out_ready);
endinterface

// File: rtl/control_sequence_packer.sv
// Control-sequence packer: collects OSR consecutive N-bit CBADC control
// vectors into an (rs1, rs2) word pair laid out for the FIR accelerator's
// S-matrix load, and queues completed pairs in a first-word-fall-through
// FIFO drained by the CPU.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   s_valid/s_data  one control vector per asserted cycle (no back-pressure)
//   flush           discard the partially assembled group
//   clear_overflow  clear the sticky overflow flag
//   bus (master)    out_valid/out_ready/out_rs1/out_rs2 head-pair handshake
//   level           FIFO occupancy, 0..DEPTH
//   overflow        sticky: a completed group was dropped on a full FIFO
module control_sequence_packer #(
  parameter int N     = 8,
  parameter int OSR   = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [N-1:0]               s_data,
  input  logic                       flush,
  input  logic                       clear_overflow,
  control_sequence_packer_if.master  bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int R2 = 32 / N;        // vectors in rs2
  localparam int R1 = OSR - R2;      // vectors in rs1
  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  generate
    if (R1 < 0 || R1 > R2) begin : g_bad_osr
      $error("control_sequence_packer: OSR does not split into 0 <= R1 <= R2");
    end
    if (N * R2 > 32) begin : g_bad_width
      $error("control_sequence_packer: N*R2 exceeds 32 bits");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("control_sequence_packer: DEPTH must be a power of 2, >= 2");
    end
  endgenerate

  // assembly state
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   asm1_q, asm1_d, asm2_q, asm2_d;

  // FIFO state
  logic [31:0]   mem1_q [DEPTH];
  logic [31:0]   mem2_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // current vector positioned in its slot; unused upper bits stay 0
  logic [31:0] ins1, ins2, pair1, pair2;
  always_comb begin
    ins1 = '0;
    ins2 = '0;
    for (int j = 0; j < R1; j++)
      if (cnt_q == CW'(j)) ins1[N*j +: N] = s_data;
    for (int k = 0; k < R2; k++)
      if (cnt_q == CW'(R1 + k)) ins2[N*k +: N] = s_data;
  end

  // final vector merged combinationally so the pushed pair is complete
  assign pair1 = asm1_q | ins1;
  assign pair2 = asm2_q | ins2;

  logic last, complete, pop, full, push, drop;
  assign last     = (cnt_q == CW'(OSR - 1));
  assign complete = s_valid && !flush && last;   // flush discards the group
  assign pop      = bus.out_valid && bus.out_ready;
  assign full     = (level_q == LW'(DEPTH));
  assign push     = complete && (!full || pop);  // full + pop frees a slot
  assign drop     = complete && !push;

  always_comb begin
    cnt_d   = cnt_q;
    asm1_d  = asm1_q;
    asm2_d  = asm2_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (flush) begin
      cnt_d  = '0;
      asm1_d = '0;
      asm2_d = '0;
    end else if (s_valid) begin
      if (last) begin
        // wraps even on a drop, so group alignment survives overflow
        cnt_d  = '0;
        asm1_d = '0;
        asm2_d = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        asm1_d = pair1;
        asm2_d = pair2;
      end
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // a drop in the same cycle beats the clear
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      asm1_q  <= '0;
      asm2_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem1_q[i] <= '0;
        mem2_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      asm1_q  <= asm1_d;
      asm2_q  <= asm2_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      // pointers wrap naturally since DEPTH is a power of 2; at full with a
      // simultaneous pop, wr_q == rd_q and the head is read before overwrite
      if (push) begin
        mem1_q[wr_q] <= pair1;
        mem2_q[wr_q] <= pair2;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_rs1   = bus.out_valid ? mem1_q[rd_q] : '0;
  assign bus.out_rs2   = bus.out_valid ? mem2_q[rd_q] : '0;
  assign level         = level_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_control_sequence_packer.sv
module tb_control_sequence_packer;
  localparam int DEPTH = 4;
  localparam int OSR8  = 7;
  localparam int R1_8  = 3;   // 7 - 32/8
  localparam int R1_3  = 10;  // 20 - 32/3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v8, fl8, clr8;
  logic [7:0] d8;
  logic [2:0] level8;
  logic       ovf8;
  logic       v3, fl3, clr3;
  logic [2:0] d3;
  logic [2:0] level3;
  logic       ovf3;

  control_sequence_packer_if bus8();
  control_sequence_packer_if bus3();

  control_sequence_packer #(.N(8), .OSR(7), .DEPTH(DEPTH)) dut8 (
    .clk(clk), .reset(reset), .s_valid(v8), .s_data(d8), .flush(fl8),
    .clear_overflow(clr8), .bus(bus8.master), .level(level8), .overflow(ovf8));

  control_sequence_packer #(.N(3), .OSR(20), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .reset(reset), .s_valid(v3), .s_data(d3), .flush(fl3),
    .clear_overflow(clr3), .bus(bus3.master), .level(level3), .overflow(ovf3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard model of the N=8 instance
  logic [63:0] q[$];
  logic [31:0] m_a1 = '0, m_a2 = '0;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  bit          known = 0;

  task automatic step8(input logic r, input logic v, input logic [7:0] d,
                       input logic f, input logic c, input logic rdy);
    logic [31:0] p1, p2;
    bit pop, cmp, drop;
    reset = r; v8 = v; d8 = d; fl8 = f; clr8 = c; bus8.out_ready = rdy;
    @(negedge clk);
    if (known) begin
      chk("vld", bus8.out_valid, q.size() != 0);
      chk("lvl", level8, q.size());
      chk("ovf", ovf8, m_ovf);
      if (q.size() > 0) begin
        chk("rs1", bus8.out_rs1, q[0][63:32]);
        chk("rs2", bus8.out_rs2, q[0][31:0]);
      end else begin
        chk("rs1_empty", bus8.out_rs1, 0);
        chk("rs2_empty", bus8.out_rs2, 0);
      end
    end
    if (r) begin
      q.delete(); m_cnt = 0; m_a1 = '0; m_a2 = '0; m_ovf = 1'b0; known = 1;
    end else begin
      p1 = m_a1; p2 = m_a2;
      if (m_cnt < R1_8) p1[8*m_cnt +: 8] = d;
      else              p2[8*(m_cnt-R1_8) +: 8] = d;
      pop  = (q.size() > 0) && rdy;
      cmp  = v && !f && (m_cnt == OSR8 - 1);
      drop = 0;
      if (pop) void'(q.pop_front());
      if (cmp) begin
        if (q.size() < DEPTH) q.push_back({p1, p2});
        else drop = 1;
      end
      if (drop)   m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (f || (v && cmp) || (v && m_cnt == OSR8 - 1)) begin
        if (f || v) begin m_cnt = 0; m_a1 = '0; m_a2 = '0; end
      end else if (v) begin
        m_cnt++; m_a1 = p1; m_a2 = p2;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step8(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
  endtask

  // group vectors are base+1 .. base+7; ready only on the final vector
  task automatic feed_grp(input int base, input logic rdy_last);
    for (int j = 0; j < OSR8; j++)
      step8(1'b0, 1'b1, 8'(base + j + 1), 1'b0, 1'b0, (j == OSR8 - 1) ? rdy_last : 1'b0);
  endtask

  initial begin
    logic [31:0] e1, e2;
    v3 = 1'b0; d3 = '0; fl3 = 1'b0; clr3 = 1'b0; bus3.out_ready = 1'b0;

    step8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_vld", bus8.out_valid, 0);
    chk("rst_lvl", level8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_rs1", bus8.out_rs1, 0);
    chk("rst_vld3", bus3.out_valid, 0);
    chk("rst_lvl3", level3, 0);

    // basic packing, one cycle latency after the 7th vector
    feed_grp(0, 1'b0);
    chk("t1_vld", bus8.out_valid, 1);
    chk("t1_rs1", bus8.out_rs1, 32'h00030201);
    chk("t1_rs2", bus8.out_rs2, 32'h07060504);
    chk("t1_lvl", level8, 1);
    idle(1, 1'b1);
    chk("t1_pop", level8, 0);
    idle(1, 1'b1);  // ready while empty is ignored

    // overflow; the 5th group's drop coincides with clear_overflow (set wins)
    for (int g = 1; g <= 4; g++) feed_grp(g * 16, 1'b0);
    for (int j = 0; j < OSR8; j++)
      step8(1'b0, 1'b1, 8'(80 + j + 1), 1'b0, (j == OSR8 - 1), 1'b0);
    chk("ov_lvl", level8, 4);
    chk("ov_flag", ovf8, 1);
    chk("ov_head1", bus8.out_rs1, 32'h00131211);
    chk("ov_head2", bus8.out_rs2, 32'h17161514);
    step8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ov_clr", ovf8, 0);
    idle(4, 1'b1);
    chk("ov_drain", level8, 0);

    // full plus simultaneous pop/push
    for (int g = 1; g <= 4; g++) feed_grp(g * 16, 1'b0);
    feed_grp(80, 1'b1);
    chk("fs_lvl", level8, 4);
    chk("fs_ovf", ovf8, 0);
    chk("fs_head", bus8.out_rs1, 32'h00232221);
    idle(5, 1'b1);

    // flush mid-group, then a fresh aligned group
    for (int j = 0; j < 3; j++) step8(1'b0, 1'b1, 8'(8'hA1 + j), 1'b0, 1'b0, 1'b0);
    step8(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    feed_grp(16, 1'b0);
    chk("fl_rs1", bus8.out_rs1, 32'h00131211);
    chk("fl_rs2", bus8.out_rs2, 32'h17161514);
    idle(1, 1'b1);
    // flush with the 7th vector: no push
    for (int j = 0; j < 6; j++) step8(1'b0, 1'b1, 8'(8'h31 + j), 1'b0, 1'b0, 1'b0);
    step8(1'b0, 1'b1, 8'h37, 1'b1, 1'b0, 1'b0);
    chk("fl_nopush", bus8.out_valid, 0);
    feed_grp(64, 1'b0);
    chk("fl_after", bus8.out_rs1, 32'h00434241);
    idle(1, 1'b1);

    // reset mid-group with two pairs queued
    feed_grp(80, 1'b0);
    feed_grp(96, 1'b0);
    for (int j = 0; j < 3; j++) step8(1'b0, 1'b1, 8'(8'hE1 + j), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_lvl", level8, 2);
    step8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_vld", bus8.out_valid, 0);
    chk("mid_rst_lvl", level8, 0);
    chk("mid_rst_ovf", ovf8, 0);
    feed_grp(112, 1'b0);
    chk("post_rst_rs1", bus8.out_rs1, 32'h00737271);
    chk("post_rst_rs2", bus8.out_rs2, 32'h77767574);
    chk("post_rst_lvl", level8, 1);
    idle(1, 1'b1);

    // N=3, OSR=20 layout: slots of 3 bits, 10 in each word
    e1 = '0; e2 = '0;
    for (int j = 0; j < 20; j++) begin
      if (j < R1_3) e1[3*j +: 3] = 3'(j % 8);
      else          e2[3*(j-R1_3) +: 3] = 3'(j % 8);
    end
    for (int j = 0; j < 20; j++) begin
      v3 = 1'b1; d3 = 3'(j % 8);
      idle(1, 1'b0);
    end
    v3 = 1'b0;
    chk("n3_vld", bus3.out_valid, 1);
    chk("n3_rs1", bus3.out_rs1, e1);
    chk("n3_rs2", bus3.out_rs2, e2);
    chk("n3_lvl", level3, 1);
    chk("n3_ovf", ovf3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
